// File: rtl/delay_line_ctrl.sv
// Host-byte command sequencer for the delay-line measurement path: decodes UART
// commands, drives tap select and launch, captures the tap word and streams results.
module delay_line_ctrl #(
    parameter int unsigned SETTLE = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic [7:0]  o_sel,
    output logic        o_launch,
    input  logic [15:0] i_taps,
    output logic        o_busy,
    output logic        o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARG     = 3'd1,
        S_LAUNCH  = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4,
        S_TX      = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_sel;
    logic        r_launch;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_busy;
    logic        r_overrun;
    logic [15:0] r_cap;
    logic [7:0]  r_settle_cnt;
    logic [7:0]  r_byte1;
    logic [7:0]  r_byte2;
    logic [1:0]  r_tx_left;

    logic [7:0]  w_count;
    logic        w_overrun_set;

    // Length of the unbroken run of ones starting at bit 0 (0..16).
    function automatic logic [7:0] lead_ones(input logic [15:0] w);
        logic [7:0] n;
        logic       stop;
        n    = 8'd0;
        stop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (w[i] && !stop) n = n + 8'd1;
            else               stop = 1'b1;
        end
        return n;
    endfunction

    assign w_count       = lead_ones(r_cap);
    assign w_overrun_set = i_rx_valid && (r_state != S_IDLE) && (r_state != S_ARG);

    // Command FSM with all outputs registered; overrun set is applied last so it beats a status clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= 8'h00;
            r_launch     <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_cap        <= 16'h0000;
            r_settle_cnt <= 8'h00;
            r_byte1      <= 8'h00;
            r_byte2      <= 8'h00;
            r_tx_left    <= 2'd0;
        end else begin
            r_launch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        r_busy <= 1'b1;
                        case (i_rx_data)
                            8'h01: r_state <= S_ARG;
                            8'h02: begin
                                r_state  <= S_LAUNCH;
                                r_launch <= 1'b1;
                            end
                            8'h04: begin
                                r_state    <= S_TX;
                                r_tx_data  <= r_sel;
                                r_tx_valid <= 1'b1;
                                r_tx_left  <= 2'd0;
                            end
                            8'h05: begin
                                r_state    <= S_TX;
                                r_tx_data  <= {7'b0000000, r_overrun};
                                r_overrun  <= 1'b0;
                                r_tx_valid <= 1'b1;
                                r_tx_left  <= 2'd0;
                            end
                            default: begin
                                r_state    <= S_TX;
                                r_tx_data  <= 8'hEE;
                                r_tx_valid <= 1'b1;
                                r_tx_left  <= 2'd0;
                            end
                        endcase
                    end
                end
                S_ARG: begin
                    if (i_rx_valid) begin
                        r_sel   <= i_rx_data;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    r_settle_cnt <= 8'(SETTLE - 1);
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_cap   <= i_taps;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                S_CAPTURE: begin
                    r_tx_data  <= r_cap[7:0];
                    r_byte1    <= r_cap[15:8];
                    r_byte2    <= w_count;
                    r_tx_left  <= 2'd2;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_TX;
                end
                S_TX: begin
                    if (r_tx_valid && i_tx_ready) begin
                        if (r_tx_left == 2'd0) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_tx_data <= r_byte1;
                            r_byte1   <= r_byte2;
                            r_tx_left <= r_tx_left - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
            if (w_overrun_set) r_overrun <= 1'b1;
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_sel      = r_sel;
    assign o_launch   = r_launch;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl: expected response bytes are queued at issue
// time and a monitor pops them on every transmit handshake.
module tb_delay_line_ctrl;

    localparam int SETTLE = 8;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [7:0]  sel;
    logic        launch;
    logic [15:0] taps;
    logic        busy;
    logic        overrun;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  model_sel = 8'h00;
    logic        model_ovr = 1'b0;
    bit          hold_low  = 1'b0;

    delay_line_ctrl #(.SETTLE(SETTLE)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .i_tx_ready (tx_ready),
        .o_sel      (sel),
        .o_launch   (launch),
        .i_taps     (taps),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int run_len(input logic [15:0] w);
        int n = 0;
        while (n < 16 && w[n]) n++;
        return n;
    endfunction

    // Transmitter back-pressure: random, or forced low on request.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop on each handshake, and require stable data while stalled.
    initial begin
        bit         pending = 1'b0;
        logic [7:0] held    = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    check("stall_valid", {31'd0, tx_valid}, 32'd1);
                    check("stall_data", {24'd0, tx_data}, {24'd0, held});
                end
                pending = 1'b0;
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        check("resp_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                    end
                end else if (tx_valid) begin
                    pending = 1'b1;
                    held    = tx_data;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_single(input logic [7:0] cmd);
        if (cmd == 8'h04) exp_q.push_back(model_sel);
        else if (cmd == 8'h05) begin
            exp_q.push_back({7'd0, model_ovr});
            model_ovr = 1'b0;
        end else exp_q.push_back(8'hEE);
        send_byte(cmd);
        check("single_valid_T1", {31'd0, tx_valid}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic do_config(input logic [7:0] arg);
        send_byte(8'h01);
        check("arg_busy", {31'd0, busy}, 32'd1);
        send_byte(arg);
        model_sel = arg;
        check("sel_update", {24'd0, sel}, {24'd0, model_sel});
        check("arg_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_measure(input logic [15:0] val, input bit inject);
        exp_q.push_back(val[7:0]);
        exp_q.push_back(val[15:8]);
        exp_q.push_back(8'(run_len(val)));
        taps = ~val;
        send_byte(8'h02);
        check("launch_T1", {31'd0, launch}, 32'd1);
        for (int k = 1; k <= SETTLE + 2; k++) begin
            @(negedge clk);
            if (k == 1) check("launch_T2", {31'd0, launch}, 32'd0);
            if (inject && k == 2) begin
                rx_valid = 1'b1;
                rx_data  = 8'h02;
            end
            if (inject && k == 3) rx_valid = 1'b0;
            if (k == SETTLE) taps = val;
            if (k == SETTLE + 1) begin
                taps = ~val;
                check("valid_before", {31'd0, tx_valid}, 32'd0);
            end
            if (k == SETTLE + 2) check("valid_rise", {31'd0, tx_valid}, 32'd1);
        end
        if (inject) model_ovr = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        taps     = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_sel", {24'd0, sel}, 32'd0);
        check("rst_misc", {29'd0, launch, busy, overrun}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_single(8'h04);
        wait_idle();
        do_config(8'h5A);
        do_single(8'h04);
        wait_idle();

        do_measure(16'h00FF, 1'b0); wait_idle();
        do_measure(16'hFFFF, 1'b0); wait_idle();
        do_measure(16'h0000, 1'b0); wait_idle();
        do_measure(16'h00FD, 1'b0); wait_idle();

        hold_low = 1'b1;
        do_measure(16'h0F0F, 1'b0);
        repeat (5) @(negedge clk);
        check("stall_first", {24'd0, tx_data}, 32'h0F);
        hold_low = 1'b0;
        wait_idle();

        do_measure(16'h0007, 1'b1);
        wait_idle();
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("sel_held", {24'd0, sel}, {24'd0, model_sel});
        do_single(8'h05);
        check("overrun_clr", {31'd0, overrun}, 32'd0);
        wait_idle();
        do_single(8'h05);
        wait_idle();
        do_single(8'h77);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            int pick = $urandom_range(0, 4);
            case (pick)
                0: do_config(8'($urandom_range(0, 255)));
                1: begin
                    logic [15:0] v = 16'($urandom);
                    int len = $urandom_range(0, 16);
                    for (int i = 0; i < len; i++) v[i] = 1'b1;
                    if (len < 16) v[len] = 1'b0;
                    do_measure(v, ($urandom_range(0, 3) == 0));
                end
                2: do_single(8'h04);
                3: do_single(8'h05);
                default: begin
                    logic [7:0] b = 8'($urandom_range(0, 255));
                    while (b == 8'h01 || b == 8'h02 || b == 8'h04 || b == 8'h05)
                        b = 8'($urandom_range(0, 255));
                    do_single(b);
                end
            endcase
            wait_idle();
        end

        do_config(8'hC3);
        hold_low = 1'b1;
        do_measure(16'h1234, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_mid_sel", {24'd0, sel}, 32'd0);
        check("rst_mid_busy", {30'd0, busy, overrun}, 32'd0);
        exp_q.delete();
        model_sel = 8'h00;
        model_ovr = 1'b0;
        hold_low  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (tx_valid) seen++;
            end
            check("no_partial_tx", seen, 32'd0);
        end
        do_single(8'h04);
        wait_idle();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

UART-byte command sequencer for the delay-line measurement datapath, running on the 48 MHz PLL clock. It decodes host command bytes from the UART receiver, configures the delay-line tap select, fires a launch pulse, waits a fixed settle time, captures the 16-bit tap thermometer word, and streams the result back through the UART transmitter. It sits between the UART byte interfaces and the delay-line core inside the top-level wrapper.

## Interface

- SETTLE, 8: number of clock cycles between the launch pulse and tap capture; legal range 1..255.
- i_clk  in  1  system clock (48 MHz PLL output).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_valid  in  1  single-cycle strobe: i_rx_data holds a received byte.
- i_rx_data  in  8  received byte.
- o_tx_valid  out  1  response byte available; held until accepted.
- o_tx_data  out  8  response byte; stable while o_tx_valid is high.
- i_tx_ready  in  1  transmitter accepts the byte in any cycle where o_tx_valid and i_tx_ready are both high.
- o_sel  out  8  tap-select configuration register driven to the delay line.
- o_launch  out  1  one-cycle launch pulse into the delay line.
- i_taps  in  16  registered tap word from the delay line; bit 0 is the first tap.
- o_busy  out  1  high in every state except IDLE.
- o_overrun  out  1  sticky flag: a byte was dropped while busy.

## Operation

- States: IDLE, ARG, LAUNCH, SETTLE, CAPTURE, TX, each registered.
- Commands are decoded in IDLE when i_rx_valid is high:
  - 0x01: go to ARG. The next received byte is written to o_sel, then return to IDLE. There is no response.
  - 0x02: measure. Go to LAUNCH, then SETTLE, then CAPTURE, then TX with 3 response bytes: taps[7:0], taps[15:8], count.
  - 0x04: read config. Go to TX with 1 byte: o_sel.
  - 0x05: status. Go to TX with 1 byte: {7'b0, o_overrun}. o_overrun clears in the same cycle the byte is loaded.
  - Any other byte: go to TX with 1 byte: 0xEE.
- count is the number of consecutive ones in the captured word starting at bit 0, in the range 0..16, zero-extended to 8 bits. Bits above the first zero are ignored. For example, 16'h00FF gives 8 and 16'h00FD gives 1.
- TX presents the bytes in order. On the final accepted byte, return to IDLE.
- If i_rx_valid arrives in any state other than IDLE or ARG, the byte is discarded and o_overrun is set to 1.
- If a status command's clear and a new overrun happen in the same cycle, the set wins.
- ARG consumes exactly one byte. It does not time out.
- o_sel is held across all commands. It changes only via 0x01 or reset.

## Timing

- Reset values: state IDLE, o_sel 0x00, o_launch 0, o_tx_valid 0, o_tx_data 0x00, o_busy 0, o_overrun 0, capture register 0.
- Reset takes effect asynchronously at any point. An in-flight response is abandoned and no partial bytes are sent after release.
- Measure command sampled at edge T:
  - o_launch is high for exactly cycle T+1.
  - SETTLE occupies cycles T+2..T+1+SETTLE.
  - i_taps is captured at the edge ending cycle T+1+SETTLE.
  - The count is computed during CAPTURE, cycle T+2+SETTLE.
  - o_tx_valid rises in cycle T+3+SETTLE with the first byte.
- Read-config, status and error commands: o_tx_valid rises in cycle T+1.
- The next byte is presented in the cycle after a handshake. o_tx_valid stays high between bytes of one response if the transmitter is ready.
- o_tx_valid falls in the cycle after the last handshake.
- o_sel updates at the edge where the argument byte is sampled.
- The earliest IDLE acceptance of a new command is the cycle after the final handshake.

## Test plan

- Reset with no stimulus: all outputs at reset values. Send 0x04: a response of 0x00 on o_tx_valid one cycle later.
- Send 0x01 then 0x5A, then 0x04: o_sel=0x5A and a single response byte 0x5A.
- Drive i_taps=16'h00FF, send 0x02 with SETTLE=8: o_launch pulses at T+1, capture at T+9, and the response is 0xFF, 0x00, 0x08. Repeat with 16'hFFFF (count 0x10), 16'h0000 (count 0x00) and 16'h00FD (count 0x01).
- Hold i_tx_ready low for 5 cycles during the measure response: o_tx_data stays stable, and there is no duplicated or lost byte.
- Send 0x02, then inject a byte during SETTLE: o_overrun=1 and the measurement is unaffected. Send 0x05: response 0x01, and o_overrun then reads 0. A second 0x05 returns 0x00.
- Send 0x77: response 0xEE. Assert i_rst_n low mid-way through a measure response: o_tx_valid drops immediately and o_sel returns to 0x00.
